// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the two-master SDRAM arbiter:
//               bus widths, the arbiter state encoding and the bundled
//               Wishbone request record handed to the output mux.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int c_adr_w  = 21;   // word address width
    localparam int c_dat_w  = 32;   // data width
    localparam int c_sel_w  = 4;    // byte-lane select width
    localparam int c_hold_w = 8;    // hold counter width (MAX_HOLD <= 255)

    // The GNT encodings equal the one-hot grant value, so the grant vector is
    // simply the state register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    // One master's request side of a Wishbone bus.
    typedef struct packed {
        logic [c_adr_w-1:0] adr;
        logic [c_dat_w-1:0] dat;
        logic [c_sel_w-1:0] sel;
        logic               we;
        logic               cyc;
        logic               stb;
    } wb_req_t;

    // Grant vector for a state; anything that is not a GNT state reads idle.
    function automatic logic [1:0] grant_of(input arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GNT0) g = 2'b01;
        if (s == GNT1) g = 2'b10;
        return g;
    endfunction

endpackage : sdram_arb_pkg
`default_nettype wire

// File: rtl/wb_master_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_master_mux
// Description : Combinational 2:1 mux that forwards the granted master's
//               Wishbone request to the shared SDRAM controller port. With no
//               grant the whole request, including cyc and stb, is zero.
// Ports       : i_grant   - one-hot grant (01 = m0, 10 = m1, 00 = idle)
//               i_m0_req  - master 0 request bundle
//               i_m1_req  - master 1 request bundle
//               o_s_req   - request bundle driven to the controller
// Revision    : 1.0 - initial release
// ============================================================================
module wb_master_mux
    import sdram_arb_pkg::*;
(
    input  logic [1:0] i_grant,
    input  wb_req_t    i_m0_req,
    input  wb_req_t    i_m1_req,
    output wb_req_t    o_s_req
);

    always_comb begin
        o_s_req = '0;
        unique case (i_grant)
            2'b01:   o_s_req = i_m0_req;
            2'b10:   o_s_req = i_m1_req;
            default: o_s_req = '0;
        endcase
    end

endmodule : wb_master_mux
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-master Wishbone arbiter in front of a shared cached SDRAM
//               controller. Master 0 is the CPU, master 1 the DMA engine.
//               A grant is held for the whole Wishbone cycle (cyc high);
//               a master that keeps cyc high is forced to yield after
//               MAX_HOLD acks when the other master is waiting. Ties from
//               idle go to the master that was not granted most recently.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               m0_* / m1_*           - Wishbone slave ports of each master
//               s_*                   - Wishbone master port to the controller
//               grant_o               - one-hot current grant
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic [c_adr_w-1:0] m0_adr_i,
    input  logic [c_dat_w-1:0] m0_dat_i,
    output logic [c_dat_w-1:0] m0_dat_o,
    input  logic               m0_stb_i,
    input  logic               m0_cyc_i,
    input  logic               m0_we_i,
    input  logic [c_sel_w-1:0] m0_sel_i,
    output logic               m0_ack_o,

    input  logic [c_adr_w-1:0] m1_adr_i,
    input  logic [c_dat_w-1:0] m1_dat_i,
    output logic [c_dat_w-1:0] m1_dat_o,
    input  logic               m1_stb_i,
    input  logic               m1_cyc_i,
    input  logic               m1_we_i,
    input  logic [c_sel_w-1:0] m1_sel_i,
    output logic               m1_ack_o,

    output logic [c_adr_w-1:0] s_adr_o,
    output logic [c_dat_w-1:0] s_dat_o,
    output logic [c_sel_w-1:0] s_sel_o,
    output logic               s_stb_o,
    output logic               s_cyc_o,
    output logic               s_we_o,
    input  logic [c_dat_w-1:0] s_dat_i,
    input  logic               s_ack_i,

    output logic [1:0]         grant_o
);

    // Saturation value and the "limit reached on this ack" threshold.
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_thr = c_hold_w'(MAX_HOLD - 1);

    arb_state_e          r_state_q, w_state_d;
    logic                r_last_q,  w_last_d;   // 0 = m0, 1 = m1 granted last
    logic [c_hold_w-1:0] r_hold_q,  w_hold_d;   // acks in the current grant

    logic                w_hold_done;
    logic [1:0]          w_grant;
    wb_req_t             w_m0_req, w_m1_req, w_s_req;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= IDLE;
            r_last_q  <= 1'b1;      // m0 wins the first tie after reset
            r_hold_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_last_q  <= w_last_d;
            r_hold_q  <= w_hold_d;
        end
    end

    // The yield test uses the count before this cycle's ack is added, so the
    // MAX_HOLD-th ack is the one that triggers the hand-over.
    assign w_hold_done = (r_hold_q >= c_hold_thr);

    // ------------------------------------------------------------------
    // Next-state logic. The grant only moves when the owner has dropped
    // cyc or on an ack cycle, so a transaction in flight (stb high, no ack
    // yet) is never preempted.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_d = r_last_q ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    w_state_d = GNT0;
                else if (m1_cyc_i)
                    w_state_d = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i)
                    w_state_d = m1_cyc_i ? GNT1 : IDLE;
                else if (s_ack_i && w_hold_done && m1_cyc_i)
                    w_state_d = GNT1;
            end
            GNT1: begin
                if (!m1_cyc_i)
                    w_state_d = m0_cyc_i ? GNT0 : IDLE;
                else if (s_ack_i && w_hold_done && m0_cyc_i)
                    w_state_d = GNT0;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Last-granted tracker and hold counter.
    always_comb begin
        w_last_d = r_last_q;
        if (w_state_d == GNT0 && r_state_q != GNT0) w_last_d = 1'b0;
        if (w_state_d == GNT1 && r_state_q != GNT1) w_last_d = 1'b1;

        w_hold_d = r_hold_q;
        if (w_state_d != r_state_q)
            w_hold_d = '0;
        else if (s_ack_i && r_state_q != IDLE && r_hold_q < c_hold_max)
            w_hold_d = r_hold_q + c_hold_w'(1);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_grant = grant_of(r_state_q);
    assign grant_o = w_grant;

    assign w_m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i,
                        we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
    assign w_m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i,
                        we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};

    wb_master_mux u_mux (
        .i_grant  (w_grant),
        .i_m0_req (w_m0_req),
        .i_m1_req (w_m1_req),
        .o_s_req  (w_s_req)
    );

    assign s_adr_o = w_s_req.adr;
    assign s_dat_o = w_s_req.dat;
    assign s_sel_o = w_s_req.sel;
    assign s_we_o  = w_s_req.we;
    assign s_cyc_o = w_s_req.cyc;
    assign s_stb_o = w_s_req.stb;

    // Acks are steered to the owner only; an ack seen while idle is dropped.
    assign m0_ack_o = s_ack_i && (r_state_q == GNT0);
    assign m1_ack_o = s_ack_i && (r_state_q == GNT1);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter (MAX_HOLD = 2).
//               Stimulus pushes expected bus snapshots and expected acks into
//               queues; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int M0 = 0, M1 = 1, NONE = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [20:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_stb_i, m0_cyc_i, m0_we_i, m1_stb_i, m1_cyc_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_ack_o, m1_ack_o, s_stb_o, s_cyc_o, s_we_o, s_ack_i;
    logic [1:0]  grant_o;

    always #5 clk = ~clk;

    sdram_arbiter #(.MAX_HOLD(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    typedef struct {
        int          at;
        string       name;
        logic [1:0]  g;
        logic        cyc, stb, we;
        logic [20:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        a0, a1;
    } snap_t;

    typedef struct {
        int          id;
        logic [31:0] dat;
    } ack_t;

    snap_t sq[$];
    ack_t  aq[$];
    int    cnt = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cnt <= cnt + 1;

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int id, input logic c, input logic s,
                           input logic w, input logic [20:0] a,
                           input logic [31:0] d, input logic [3:0] se);
        if (id == M0) begin
            m0_cyc_i = c; m0_stb_i = s; m0_we_i = w;
            m0_adr_i = a; m0_dat_i = d; m0_sel_i = se;
        end else begin
            m1_cyc_i = c; m1_stb_i = s; m1_we_i = w;
            m1_adr_i = a; m1_dat_i = d; m1_sel_i = se;
        end
    endtask

    task automatic slave(input logic ack, input logic [31:0] d);
        s_ack_i = ack;
        s_dat_i = d;
    endtask

    task automatic exp_ack(input int id, input logic [31:0] d);
        ack_t a;
        a.id  = id;
        a.dat = d;
        aq.push_back(a);
    endtask

    // Expected bus this cycle: the driven request of master src, or zeros.
    task automatic snap(input string nm, input logic [1:0] g, input int src,
                        input logic a0, input logic a1);
        snap_t s;
        s.at = cnt; s.name = nm; s.g = g; s.a0 = a0; s.a1 = a1;
        if (src == M0) begin
            s.cyc = m0_cyc_i; s.stb = m0_stb_i; s.we = m0_we_i;
            s.adr = m0_adr_i; s.dat = m0_dat_i; s.sel = m0_sel_i;
        end else if (src == M1) begin
            s.cyc = m1_cyc_i; s.stb = m1_stb_i; s.we = m1_we_i;
            s.adr = m1_adr_i; s.dat = m1_dat_i; s.sel = m1_sel_i;
        end else begin
            s.cyc = 1'b0; s.stb = 1'b0; s.we = 1'b0;
            s.adr = '0; s.dat = '0; s.sel = '0;
        end
        sq.push_back(s);
    endtask

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    snap_t       mon_s;
    ack_t        mon_a;
    logic [63:0] mon_act, mon_exp;

    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].at <= cnt) begin
            mon_s = sq.pop_front();
            checks++;
            mon_act = {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
                       s_sel_o, m0_ack_o, m1_ack_o};
            mon_exp = {mon_s.g, mon_s.cyc, mon_s.stb, mon_s.we, mon_s.adr,
                       mon_s.dat, mon_s.sel, mon_s.a0, mon_s.a1};
            if (mon_s.at != cnt) begin
                errors++;
                $display("FAIL %s: snapshot for cycle %0d not checked in time (now %0d)",
                         mon_s.name, mon_s.at, cnt);
            end else if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got {gnt,cyc,stb,we,adr,dat,sel,ack0,ack1}=%h expected %h",
                         mon_s.name, mon_act, mon_exp);
            end
        end
        if (m0_ack_o === 1'b1 || m1_ack_o === 1'b1) begin
            checks++;
            if (aq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack0=%b ack1=%b at cycle %0d, expected none",
                         m0_ack_o, m1_ack_o, cnt);
            end else begin
                mon_a = aq.pop_front();
                if ({m0_ack_o, m1_ack_o} !== ((mon_a.id == M0) ? 2'b10 : 2'b01) ||
                    m0_dat_o !== mon_a.dat || m1_dat_o !== mon_a.dat) begin
                    errors++;
                    $display("FAIL ack_m%0d: got ack0=%b ack1=%b dat0=%h dat1=%h expected data %h",
                             mon_a.id, m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o, mon_a.dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------
    initial begin
        rst_i = 1'b1;
        drive_m(M0, 0, 0, 0, '0, '0, '0);
        drive_m(M1, 0, 0, 0, '0, '0, '0);
        slave(0, '0);

        // Reset dominates a request.
        tick();
        drive_m(M0, 1, 1, 0, 21'h10, '0, 4'hF);
        snap("reset_idle", 2'b00, NONE, 0, 0);
        tick();
        snap("reset_hold_req", 2'b00, NONE, 0, 0);
        drive_m(M0, 0, 0, 0, '0, '0, '0);
        rst_i = 1'b0;

        // Ack while idle is dropped.
        tick();
        slave(1, 32'h5A5A_5A5A);
        snap("spurious_ack", 2'b00, NONE, 0, 0);
        tick();
        slave(0, '0);
        snap("idle_after_spur", 2'b00, NONE, 0, 0);

        // Tie after reset: m0 first, then m1 with no idle gap.
        tick();
        drive_m(M0, 1, 1, 1, 21'h100, 32'h0000_0100, 4'hF);
        drive_m(M1, 1, 1, 0, 21'h200, 32'h0, 4'h3);
        snap("tie_req", 2'b00, NONE, 0, 0);
        tick();
        slave(1, 32'h1111_1111); exp_ack(M0, 32'h1111_1111);
        snap("tie_gnt_m0", 2'b01, M0, 1, 0);
        tick();
        slave(0, '0);
        drive_m(M0, 0, 0, 0, '0, '0, '0);
        snap("tie_m0_release", 2'b01, M0, 0, 0);
        tick();
        slave(1, 32'h2222_2222); exp_ack(M1, 32'h2222_2222);
        snap("tie_gnt_m1", 2'b10, M1, 0, 1);
        tick();
        slave(0, '0);
        drive_m(M1, 0, 0, 0, '0, '0, '0);
        snap("tie_m1_release", 2'b10, M1, 0, 0);
        tick();
        snap("tie_idle", 2'b00, NONE, 0, 0);

        // Single read by m0, ack three cycles after the request.
        tick();
        drive_m(M0, 1, 1, 0, 21'h000010, '0, 4'hF);
        snap("single_req", 2'b00, NONE, 0, 0);
        tick();
        snap("single_c1", 2'b01, M0, 0, 0);
        tick();
        snap("single_c2", 2'b01, M0, 0, 0);
        tick();
        slave(1, 32'hDEAD_BEEF); exp_ack(M0, 32'hDEAD_BEEF);
        snap("single_ack", 2'b01, M0, 1, 0);
        tick();
        slave(0, '0);
        drive_m(M0, 0, 0, 0, '0, '0, '0);
        snap("single_release", 2'b01, M0, 0, 0);
        tick();
        snap("single_idle", 2'b00, NONE, 0, 0);

        // Hold limit of 2: m0 yields after its 2nd ack while m1 waits.
        tick();
        drive_m(M0, 1, 1, 1, 21'h300, 32'hA0, 4'h1);
        snap("hold_req", 2'b00, NONE, 0, 0);
        tick();
        drive_m(M1, 1, 1, 0, 21'h400, 32'h0, 4'hC);
        slave(1, 32'h0000_A001); exp_ack(M0, 32'h0000_A001);
        snap("hold_ack1", 2'b01, M0, 1, 0);
        tick();
        drive_m(M0, 1, 1, 1, 21'h301, 32'hA1, 4'h2);
        slave(1, 32'h0000_A002); exp_ack(M0, 32'h0000_A002);
        snap("hold_ack2", 2'b01, M0, 1, 0);
        tick();
        drive_m(M0, 1, 1, 1, 21'h302, 32'hA2, 4'h4);
        slave(0, '0);
        snap("hold_switch", 2'b10, M1, 0, 0);
        tick();
        slave(1, 32'h0000_B0B0); exp_ack(M1, 32'h0000_B0B0);
        snap("hold_m1_ack", 2'b10, M1, 0, 1);
        tick();
        slave(0, '0);
        drive_m(M1, 0, 0, 0, '0, '0, '0);
        snap("hold_m1_release", 2'b10, M1, 0, 0);
        tick();
        slave(1, 32'h0000_A003); exp_ack(M0, 32'h0000_A003);
        snap("hold_regrant", 2'b01, M0, 1, 0);
        tick();
        slave(0, '0);
        drive_m(M0, 0, 0, 0, '0, '0, '0);
        snap("hold_m0_release", 2'b01, M0, 0, 0);
        tick();
        snap("hold_idle", 2'b00, NONE, 0, 0);

        // No preemption while m0 waits 6 cycles; m0 drops cyc on its ack.
        tick();
        drive_m(M0, 1, 1, 0, 21'h500, '0, 4'hF);
        snap("np_req", 2'b00, NONE, 0, 0);
        tick();
        drive_m(M1, 1, 1, 0, 21'h600, '0, 4'hF);
        snap("np_wait", 2'b01, M0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            snap("np_wait", 2'b01, M0, 0, 0);
        end
        tick();
        slave(1, 32'hC0FF_EE00); exp_ack(M0, 32'hC0FF_EE00);
        drive_m(M0, 0, 0, 0, '0, '0, '0);
        snap("np_ack_drop", 2'b01, M0, 1, 0);
        tick();
        slave(0, '0);
        snap("np_handover", 2'b10, M1, 0, 0);

        // Reset during m1's pending read, then a stray ack.
        tick();
        rst_i = 1'b1;
        snap("rst_assert", 2'b10, M1, 0, 0);
        tick();
        snap("rst_abort", 2'b00, NONE, 0, 0);
        tick();
        rst_i = 1'b0;
        drive_m(M1, 0, 0, 0, '0, '0, '0);
        slave(1, 32'h0000_0077);
        snap("rst_stray_ack", 2'b00, NONE, 0, 0);
        tick();
        slave(0, '0);
        snap("rst_idle", 2'b00, NONE, 0, 0);

        tick();
        tick();
        checks++;
        if (sq.size() != 0 || aq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d snapshots and %0d acks left, expected 0 and 0",
                     sq.size(), aq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sdram_arbiter
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning: acks a master may receive per grant while the other master is requesting (range 1..255).
REQ-002 Port clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 Port rst_i  input  1  reset, synchronous, active-high.
REQ-004 Ports m0_adr_i/m1_adr_i  input  21  word address, master 0 (CPU) / master 1 (DMA).
REQ-005 Ports m0_dat_i/m1_dat_i  input  32  write data.
REQ-006 Ports m0_dat_o/m1_dat_o  output  32  read data.
REQ-007 Ports m0_stb_i, m0_cyc_i, m0_we_i, m1_stb_i, m1_cyc_i, m1_we_i  input  1 each  Wishbone strobe, cycle and write enable.
REQ-008 Ports m0_sel_i/m1_sel_i  input  4  byte lane selects.
REQ-009 Ports m0_ack_o/m1_ack_o  output  1  per-master acknowledge.
REQ-010 Ports s_adr_o 21, s_dat_o 32, s_sel_o 4, s_stb_o 1, s_cyc_o 1, s_we_o 1  output  Wishbone master to the shared cached SDRAM controller.
REQ-011 Ports s_dat_i  input  32, s_ack_i  input  1  read data and acknowledge from the SDRAM controller.
REQ-012 Port grant_o  output  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, GNT0, GNT1; grant_o SHALL decode the state.
REQ-014 IDLE: if exactly one mi_cyc_i is high, go to GNTi next cycle; if both are high, grant the master not granted most recently (register last); if none are high, stay in IDLE.
REQ-015 Arbitration latency SHALL be one cycle: the request is seen in IDLE, and the granted stb appears on s_stb_o in the following cycle.
REQ-016 In GNTi, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally follow master i; in IDLE all of them SHALL be 0.
REQ-017 mi_ack_o SHALL be s_ack_i AND (state == GNTi); the non-granted master's ack SHALL be 0.
REQ-018 m0_dat_o and m1_dat_o SHALL both carry s_dat_i unconditionally.
REQ-019 A hold counter SHALL increment on each s_ack_i in a GNT state, saturate at MAX_HOLD, and clear on every state change.
REQ-020 GNTi with mi_cyc_i low: go to GNTj (j = other master) if mj_cyc_i is high, else go to IDLE.
REQ-021 GNTi, on an s_ack_i cycle where the counter value before increment is MAX_HOLD-1 or more and mj_cyc_i is high: go to GNTj next cycle. Master i keeps waiting with stb masked, with no ack until it is re-granted.
REQ-022 Grant SHALL never change while the granted master has stb high and no ack has been received (transaction in flight).
REQ-023 An s_ack_i received in IDLE SHALL be ignored.
REQ-024 If mi_cyc_i drops and s_ack_i is high in the same cycle, mi_ack_o SHALL still pulse and REQ-020 applies.
REQ-025 last SHALL update to i whenever state enters GNTi.

Reset
REQ-026 On rst_i high at a clock edge: state = IDLE, last = 1 (so m0 wins the first tie), counter = 0.
REQ-027 During reset all s_* outputs, both acks and grant_o SHALL be 0 from the next edge on.
REQ-028 Reset asserted mid-transaction SHALL abort it without waiting for s_ack_i.

Structure
REQ-029 A shared package sdram_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1) and the address (21) and data (32) width constants.
REQ-030 The output mux SHALL be one sub-module, wb_master_mux: 2:1, selected by grant, zeroed when idle.
REQ-031 The arbiter FSM SHALL be in the top module.

Verification
REQ-032 Single request: m0 reads adr 0x000010 with cyc/stb high at cycle 0; s_ack_i with 0xDEADBEEF at cycle 3 -> grant_o=01 at cycle 1, s_stb_o high cycles 1-3, m0_ack_o only at cycle 3, m0_dat_o=0xDEADBEEF.
REQ-033 Tie after reset: m0 and m1 raise cyc in the same cycle -> m0 is granted first; after m0 drops cyc, m1 is granted the next cycle with no IDLE cycle.
REQ-034 Hold limit: MAX_HOLD=2, m0 does back-to-back writes with m1 requesting -> after m0's 2nd ack, grant_o=10 the next cycle; m0 stb is masked until m1 releases.
REQ-035 No preemption in flight: m1 requests while m0 waits 6 cycles for its ack -> grant stays 01 until the ack cycle; m1_ack_o stays 0 throughout.
REQ-036 Reset mid-operation: rst_i asserted during a pending m1 read -> next cycle s_stb_o=0, s_cyc_o=0, grant_o=00; a stray s_ack_i one cycle later is ignored.
REQ-037 Spurious ack: s_ack_i pulsed in IDLE -> m0_ack_o=m1_ack_o=0 and the state is unchanged.
